// File: rtl/pwm_cfg_sched.sv
// pwm_cfg_sched: double-buffered PWM configuration with carrier-aligned commit.
//
// Writes land in a shadow bank (24 angles, frequency, min/max pulse width).
// A commit request arms the block. The next carrier sync pulse copies the whole
// shadow bank into the active bank on one edge, so every active output changes
// together. If no sync arrives within SYN_TIMEOUT cycles, the request is dropped
// and o_err pulses.
//
// Optional feature: define PWM_CFG_CHECK_EN to reject inconsistent shadow
// settings. A commit is refused when Min >= Max or Frequency < Max; in that
// case o_err pulses instead of o_commit_done.
//
// Ports:
//   i_clk, i_reset             clock and asynchronous active-high reset
//   i_wr_valid/o_wr_ready      write handshake
//   i_wr_addr, i_wr_data       address map: 0..23 angles, 24 freq, 25 min, 26 max
//   i_commit_req               request a shadow-to-active commit
//   i_syn                      carrier sync pulse
//   o_initi_angle_BUS          active angles; module 1 at [383:368]
//   o_Frequency                active carrier period
//   o_PulWidth_Min             active minimum pulse width
//   o_PulWidth_Max             active maximum pulse width
//   o_busy                     high while armed and waiting for sync
//   o_commit_done              pulses for one cycle when a commit completes
//   o_err                      pulses for one cycle on a bad address, a timeout
//                              or a rejected commit
module pwm_cfg_sched #(
    parameter int unsigned SYN_TIMEOUT = 65535,
    parameter logic [15:0] FREQ_RST    = 16'd2000,
    parameter logic [15:0] PW_MIN_RST  = 16'd20,
    parameter logic [15:0] PW_MAX_RST  = 16'd1980
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr_valid,
    output logic         o_wr_ready,
    input  logic [4:0]   i_wr_addr,
    input  logic [15:0]  i_wr_data,
    input  logic         i_commit_req,
    input  logic         i_syn,
    output logic [383:0] o_initi_angle_BUS,
    output logic [15:0]  o_Frequency,
    output logic [15:0]  o_PulWidth_Min,
    output logic [15:0]  o_PulWidth_Max,
    output logic         o_busy,
    output logic         o_commit_done,
    output logic         o_err
);

    localparam int unsigned NumAng     = 24;
    localparam logic [15:0] TimeoutCnt = 16'(SYN_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StArmed, StCommit} state_t;

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q;
    logic        err_q;

    logic [15:0] sh_ang  [NumAng];
    logic [15:0] act_ang [NumAng];
    logic [15:0] sh_freq, sh_min, sh_max;
    logic [15:0] act_freq, act_min, act_max;

    logic wr_fire;
    logic addr_valid;
    logic timeout;
    logic commit_go;
    logic copy_en;
    logic commit_ok;

    assign wr_fire    = i_wr_valid && o_wr_ready;
    assign addr_valid = (i_wr_addr < 5'd27);
    assign timeout    = (state_q == StArmed) && (wait_cnt_q == TimeoutCnt);
    assign commit_go  = (state_q == StArmed) && i_syn;

`ifdef PWM_CFG_CHECK_EN
    logic shadow_ok;
    logic commit_ok_q;

    assign shadow_ok = (sh_min < sh_max) && (sh_freq >= sh_max);
    assign copy_en   = commit_go && shadow_ok;
    assign commit_ok = commit_ok_q;

    // Verdict is taken on entry to COMMIT and decides which pulse COMMIT emits.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            commit_ok_q <= 1'b0;
        end else if (commit_go) begin
            commit_ok_q <= shadow_ok;
        end
    end
`else
    assign copy_en   = commit_go;
    assign commit_ok = 1'b1;
`endif

    // FSM state register and wait counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= (state_q == StArmed) ? wait_cnt_q + 16'd1 : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (i_commit_req) state_d = StArmed;
            // Sync beats a timeout that lands in the same cycle.
            StArmed:  if (i_syn) state_d = StCommit;
                      else if (timeout) state_d = StIdle;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Shadow bank. Writes are only possible in IDLE, so they never collide with the copy.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NumAng; i++) sh_ang[i] <= '0;
            sh_freq <= FREQ_RST;
            sh_min  <= PW_MIN_RST;
            sh_max  <= PW_MAX_RST;
            err_q   <= 1'b0;
        end else begin
            err_q <= wr_fire && !addr_valid;
            if (wr_fire && addr_valid) begin
                for (int i = 0; i < NumAng; i++) begin
                    if (i_wr_addr == 5'(i)) sh_ang[i] <= i_wr_data;
                end
                if (i_wr_addr == 5'd24) sh_freq <= i_wr_data;
                if (i_wr_addr == 5'd25) sh_min  <= i_wr_data;
                if (i_wr_addr == 5'd26) sh_max  <= i_wr_data;
            end
        end
    end

    // Active bank, loaded on the edge into COMMIT so new values show while done is high.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NumAng; i++) act_ang[i] <= '0;
            act_freq <= FREQ_RST;
            act_min  <= PW_MIN_RST;
            act_max  <= PW_MAX_RST;
        end else if (copy_en) begin
            for (int i = 0; i < NumAng; i++) act_ang[i] <= sh_ang[i];
            act_freq <= sh_freq;
            act_min  <= sh_min;
            act_max  <= sh_max;
        end
    end

    always_comb begin
        o_initi_angle_BUS = '0;
        for (int i = 0; i < NumAng; i++) begin
            o_initi_angle_BUS[(NumAng - 1 - i) * 16 +: 16] = act_ang[i];
        end
    end

    assign o_Frequency    = act_freq;
    assign o_PulWidth_Min = act_min;
    assign o_PulWidth_Max = act_max;

    // Ready is held low while reset is asserted even though the state already reads IDLE.
    assign o_wr_ready    = (state_q == StIdle) && !i_reset;
    assign o_busy        = (state_q == StArmed);
    assign o_commit_done = (state_q == StCommit) && commit_ok;
    assign o_err         = err_q
                         || (timeout && !i_syn)
                         || ((state_q == StCommit) && !commit_ok);

endmodule
